// File: rtl/dmem_pkg.sv
// Shared types and helpers for the RNS data-memory arbiter.
package dmem_pkg;
  localparam int ADDR_W = 8;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  function automatic int word_w(input int num_domains);
    return num_domains * 8;
  endfunction
endpackage

// File: rtl/dmem_arbiter.sv
// Shares the data-memory read/write ports between the CPU and the host port,
// after sweeping every entry to zero following reset.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int NUM_DOMAINS  = 1,
  parameter int DEPTH        = 256,
  parameter int CLR_ON_RESET = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             cpu_load,
  input  logic                             cpu_store,
  input  logic [ADDR_W-1:0]                cpu_rd_addr,
  input  logic [ADDR_W-1:0]                cpu_wr_addr,
  input  logic [word_w(NUM_DOMAINS)-1:0]   cpu_wr_data,
  output logic                             cpu_stall,
  input  logic                             host_req,
  input  logic                             host_we,
  input  logic [ADDR_W-1:0]                host_addr,
  input  logic [word_w(NUM_DOMAINS)-1:0]   host_wdata,
  output logic                             host_gnt,
  output logic                             host_rvalid,
  output logic [word_w(NUM_DOMAINS)-1:0]   host_rdata,
  output logic [ADDR_W-1:0]                mem_rd_addr,
  output logic [ADDR_W-1:0]                mem_wr_addr,
  output logic [word_w(NUM_DOMAINS)-1:0]   mem_wr_data,
  output logic                             mem_store,
  input  logic [word_w(NUM_DOMAINS)-1:0]   mem_rdata,
  output logic                             init_busy
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]     STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [ADDR_W-1:0] CLR_LAST   = ADDR_W'(DEPTH - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt;
  logic [SW-1:0]     starve_cnt;
  logic              cpu_req;
  logic              host_own;

  assign cpu_req = cpu_load | cpu_store;

  always_comb begin
    state_nxt   = state;
    host_own    = 1'b0;
    cpu_stall   = 1'b0;
    host_gnt    = 1'b0;
    init_busy   = 1'b0;
    mem_rd_addr = cpu_rd_addr;
    mem_wr_addr = cpu_wr_addr;
    mem_wr_data = cpu_wr_data;
    mem_store   = 1'b0;
    case (state)
      CLEAR: begin
        mem_store   = 1'b1;
        mem_wr_addr = clr_cnt;
        mem_wr_data = '0;
        cpu_stall   = 1'b1;
        init_busy   = 1'b1;
        if (clr_cnt == CLR_LAST) state_nxt = RUN;
      end
      RUN: begin
        // CPU wins unless the host has been starved for the full limit.
        host_own  = host_req & (~cpu_req | (starve_cnt == STARVE_MAX));
        cpu_stall = cpu_req & host_own;
        if (host_own) begin
          host_gnt = 1'b1;
          if (host_we) begin
            mem_store   = 1'b1;
            mem_wr_addr = host_addr;
            mem_wr_data = host_wdata;
          end else begin
            mem_rd_addr = host_addr;
          end
        end else begin
          mem_store = cpu_store;
        end
      end
      default: state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= (CLR_ON_RESET != 0) ? CLEAR : RUN;
      clr_cnt     <= '0;
      starve_cnt  <= '0;
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
    end else begin
      state       <= state_nxt;
      clr_cnt     <= (state == CLEAR) ? clr_cnt + ADDR_W'(1) : '0;
      if (state == RUN && host_req && !host_own) begin
        if (starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + SW'(1);
      end else begin
        starve_cnt <= '0;
      end
      host_rvalid <= host_own & ~host_we;
      if (host_own && !host_we) host_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: clear sweep, arbitration table,
// starvation override and a host-read scoreboard.
module tb_dmem_arbiter;
  logic       clk = 1'b0;
  logic       reset;
  logic       cpu_load, cpu_store;
  logic [7:0] cpu_rd_addr, cpu_wr_addr, cpu_wr_data;
  logic       cpu_stall;
  logic       host_req, host_we;
  logic [7:0] host_addr, host_wdata;
  logic       host_gnt, host_rvalid;
  logic [7:0] host_rdata;
  logic [7:0] mem_rd_addr, mem_wr_addr, mem_wr_data;
  logic       mem_store;
  logic [7:0] mem_rdata;
  logic       init_busy;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  logic       preload;
  logic [7:0] sb [$];

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_load(cpu_load), .cpu_store(cpu_store),
    .cpu_rd_addr(cpu_rd_addr), .cpu_wr_addr(cpu_wr_addr), .cpu_wr_data(cpu_wr_data),
    .cpu_stall(cpu_stall),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_rd_addr(mem_rd_addr), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_store(mem_store), .mem_rdata(mem_rdata), .init_busy(init_busy)
  );

  // Memory model: combinational read, write on the clock edge.
  assign mem_rdata = mem[mem_rd_addr];
  always @(posedge clk) begin
    if (preload) begin
      for (int k = 0; k < 256; k++) mem[k] <= 8'hFF;
    end else if (mem_store) begin
      mem[mem_wr_addr] <= mem_wr_data;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every host_rvalid must match the oldest expected read word.
  always @(negedge clk) begin
    if (host_rvalid) begin
      if (sb.size() == 0) chk("rvalid_unexpected", 32'(host_rvalid), 32'd0);
      else chk("host_rdata", 32'(host_rdata), 32'(sb.pop_front()));
    end
  end

  task automatic idle_inputs();
    cpu_load = 0; cpu_store = 0; cpu_rd_addr = 0; cpu_wr_addr = 0; cpu_wr_data = 0;
    host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0;
  endtask

  // Runs n sweep cycles from the current one, expecting addresses start..start+n-1.
  task automatic sweep(input int start, input int n, input string name);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      #1;
      if (init_busy !== 1'b1 || mem_store !== 1'b1 || mem_wr_addr !== 8'(start + i) ||
          mem_wr_data !== 8'h00 || cpu_stall !== 1'b1 || host_gnt !== 1'b0) bad++;
      @(negedge clk);
    end
    chk(name, 32'(bad), 32'd0);
  endtask

  typedef struct {
    logic ld, st, hreq, hwe;
    logic [7:0] crd, cwr, cwd, ha, hwd;
    logic e_stall, e_gnt, e_store;
    logic [7:0] e_rd, e_wr, e_wd;
  } vec_t;

  vec_t vt [10];

  initial begin
    int bad;
    vt[0] = '{0,0,0,0, 8'h30,8'h40,8'h77,8'h00,8'h00, 0,0,0, 8'h30,8'h40,8'h77};
    vt[1] = '{1,0,0,0, 8'h31,8'h41,8'h78,8'h00,8'h00, 0,0,0, 8'h31,8'h41,8'h78};
    vt[2] = '{0,1,0,0, 8'h32,8'h42,8'h11,8'h00,8'h00, 0,0,1, 8'h32,8'h42,8'h11};
    vt[3] = '{1,1,0,0, 8'h42,8'h43,8'h22,8'h00,8'h00, 0,0,1, 8'h42,8'h43,8'h22};
    vt[4] = '{0,0,1,0, 8'h33,8'h44,8'h99,8'h42,8'h00, 0,1,0, 8'h42,8'h44,8'h99};
    vt[5] = '{0,0,1,1, 8'h34,8'h45,8'h99,8'h50,8'h66, 0,1,1, 8'h34,8'h50,8'h66};
    vt[6] = '{1,0,1,0, 8'h35,8'h46,8'h99,8'h43,8'h00, 0,0,0, 8'h35,8'h46,8'h99};
    vt[7] = '{0,1,1,1, 8'h36,8'h47,8'h88,8'h51,8'h12, 0,0,1, 8'h36,8'h47,8'h88};
    vt[8] = '{0,0,1,0, 8'h37,8'h48,8'h99,8'h50,8'h00, 0,1,0, 8'h50,8'h48,8'h99};
    vt[9] = '{0,0,1,0, 8'h38,8'h49,8'h99,8'h43,8'h00, 0,1,0, 8'h43,8'h49,8'h99};
    for (int k = 0; k < 256; k++) ref_mem[k] = 8'h00;

    // Reset and full clear sweep.
    idle_inputs();
    reset = 1; preload = 1;
    @(negedge clk);
    preload = 0;
    @(negedge clk);
    #1;
    chk("reset_rvalid", 32'(host_rvalid), 32'd0);
    chk("reset_rdata", 32'(host_rdata), 32'd0);
    chk("reset_init_busy", 32'(init_busy), 32'd1);
    reset = 0; cpu_load = 1; cpu_rd_addr = 8'h10;
    sweep(0, 256, "clear_sweep");
    #1;
    chk("run_init_busy", 32'(init_busy), 32'd0);
    chk("run_cpu_stall", 32'(cpu_stall), 32'd0);
    bad = 0;
    for (int k = 0; k < 256; k++) if (mem[k] !== 8'h00) bad++;
    chk("mem_cleared", 32'(bad), 32'd0);

    // CPU store with host idle.
    @(negedge clk);
    cpu_load = 0; cpu_store = 1; cpu_wr_addr = 8'h10; cpu_wr_data = 8'h3A;
    #1;
    chk("cpu_st_store", 32'(mem_store), 32'd1);
    chk("cpu_st_addr", 32'(mem_wr_addr), 32'h10);
    chk("cpu_st_data", 32'(mem_wr_data), 32'h3A);
    chk("cpu_st_stall", 32'(cpu_stall), 32'd0);
    chk("cpu_st_gnt", 32'(host_gnt), 32'd0);
    ref_mem[8'h10] = 8'h3A;

    // Host read, then two back-to-back reads.
    @(negedge clk);
    idle_inputs();
    host_req = 1; host_we = 0; host_addr = 8'h10;
    #1;
    chk("host_rd_gnt", 32'(host_gnt), 32'd1);
    chk("host_rd_addr", 32'(mem_rd_addr), 32'h10);
    chk("host_rd_store", 32'(mem_store), 32'd0);
    sb.push_back(ref_mem[8'h10]);
    @(negedge clk);
    host_req = 0;
    #1;
    chk("host_rvalid_1", 32'(host_rvalid), 32'd1);
    chk("host_rdata_3a", 32'(host_rdata), 32'h3A);
    @(negedge clk);
    #1;
    chk("host_rvalid_pulse", 32'(host_rvalid), 32'd0);
    host_req = 1;
    for (int k = 0; k < 2; k++) begin
      sb.push_back(ref_mem[8'h10]);
      @(negedge clk);
    end
    host_req = 0;
    #1;
    chk("b2b_rvalid_2", 32'(host_rvalid), 32'd1);
    @(negedge clk);

    // Starvation: CPU loads continuously, host write waits.
    cpu_load = 1; cpu_rd_addr = 8'h10;
    host_req = 1; host_we = 1; host_addr = 8'h20; host_wdata = 8'h55;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (host_gnt !== 1'b0 || cpu_stall !== 1'b0 || mem_rd_addr !== 8'h10 || mem_store !== 1'b0) bad++;
      @(negedge clk);
    end
    chk("starve_denied", 32'(bad), 32'd0);
    #1;
    chk("starve_gnt", 32'(host_gnt), 32'd1);
    chk("starve_stall", 32'(cpu_stall), 32'd1);
    chk("starve_wr_addr", 32'(mem_wr_addr), 32'h20);
    chk("starve_store", 32'(mem_store), 32'd1);
    ref_mem[8'h20] = 8'h55;
    @(negedge clk);
    #1;
    chk("starve_resume_gnt", 32'(host_gnt), 32'd0);
    chk("starve_resume_stall", 32'(cpu_stall), 32'd0);
    chk("starve_mem", 32'(mem[8'h20]), 32'h55);
    @(negedge clk);
    idle_inputs();
    @(negedge clk);

    // Arbitration table, idle cycle between entries.
    for (int v = 0; v < 10; v++) begin
      cpu_load = vt[v].ld; cpu_store = vt[v].st; host_req = vt[v].hreq; host_we = vt[v].hwe;
      cpu_rd_addr = vt[v].crd; cpu_wr_addr = vt[v].cwr; cpu_wr_data = vt[v].cwd;
      host_addr = vt[v].ha; host_wdata = vt[v].hwd;
      #1;
      chk($sformatf("vec%0d_stall", v), 32'(cpu_stall), 32'(vt[v].e_stall));
      chk($sformatf("vec%0d_gnt", v), 32'(host_gnt), 32'(vt[v].e_gnt));
      chk($sformatf("vec%0d_store", v), 32'(mem_store), 32'(vt[v].e_store));
      chk($sformatf("vec%0d_rd", v), 32'(mem_rd_addr), 32'(vt[v].e_rd));
      chk($sformatf("vec%0d_wr", v), 32'(mem_wr_addr), 32'(vt[v].e_wr));
      chk($sformatf("vec%0d_wd", v), 32'(mem_wr_data), 32'(vt[v].e_wd));
      if (vt[v].e_store) ref_mem[vt[v].e_wr] = vt[v].e_wd;
      if (vt[v].e_gnt && !vt[v].hwe) sb.push_back(ref_mem[vt[v].ha]);
      @(negedge clk);
      idle_inputs();
      @(negedge clk);
    end
    bad = 0;
    for (int k = 0; k < 256; k++) if (mem[k] !== ref_mem[k]) bad++;
    chk("mem_contents", 32'(bad), 32'd0);

    // Reset during a host read drops the rvalid; sweep restarts.
    host_req = 1; host_we = 0; host_addr = 8'h10; reset = 1;
    @(negedge clk);
    reset = 0; host_req = 0;
    #1;
    chk("rst_drop_rvalid", 32'(host_rvalid), 32'd0);
    chk("rst_drop_rdata", 32'(host_rdata), 32'd0);
    sweep(0, 100, "sweep_partial");
    #1;
    chk("sweep_at_100", 32'(mem_wr_addr), 32'd100);
    reset = 1;
    @(negedge clk);
    reset = 0;
    sweep(0, 250, "sweep_restart_a");
    for (int k = 0; k < 256; k++) ref_mem[k] = 8'h00;
    // Host read arrives during the tail of the sweep and must wait.
    host_req = 1; host_we = 0; host_addr = 8'h05;
    sweep(250, 6, "sweep_restart_b");
    #1;
    chk("clr_held_gnt", 32'(host_gnt), 32'd1);
    chk("clr_held_addr", 32'(mem_rd_addr), 32'h05);
    chk("clr_held_busy", 32'(init_busy), 32'd0);
    sb.push_back(ref_mem[8'h05]);
    @(negedge clk);
    idle_inputs();
    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Owns the single read port and single write port of the RNS data memory and shares them between the CPU load/store path and a host/debug port. After reset it sequences a one-address-per-cycle clear of all memory entries, which replaces a whole-array reset that cannot be synthesised. It then arbitrates each cycle: the CPU has priority, and a starvation counter guarantees host forward progress. It sits between the pipeline's memory stage, the debug loader and the data memory.

Parameters:
NUM_DOMAINS, 1, number of 8-bit RNS residues per memory word.
DEPTH, 256, memory entries; the address width is fixed at 8.
CLR_ON_RESET, 1, 1 = run the CLEAR sweep after reset; 0 = go directly to RUN.
STARVE_LIMIT, 4, consecutive denied host-request cycles before the host is forced in.

Ports:
clk  in  1  clock.
reset  in  1  reset, synchronous, active-high.
cpu_load  in  1  CPU read request this cycle.
cpu_store  in  1  CPU write request this cycle.
cpu_rd_addr  in  8  CPU read address.
cpu_wr_addr  in  8  CPU write address.
cpu_wr_data  in  NUM_DOMAINS*8  CPU write word, {D1,D2,...}.
cpu_stall  out  1  CPU access not performed; the pipeline holds.
host_req  in  1  host access request; held until granted.
host_we  in  1  1 = write, 0 = read; stable while host_req is high.
host_addr  in  8  host address.
host_wdata  in  NUM_DOMAINS*8  host write word.
host_gnt  out  1  host access performed this cycle (combinational).
host_rvalid  out  1  host_rdata valid; 1-cycle pulse.
host_rdata  out  NUM_DOMAINS*8  registered read word.
mem_rd_addr  out  8  to the memory read port.
mem_wr_addr  out  8  to the memory write port.
mem_wr_data  out  NUM_DOMAINS*8  to the memory write port.
mem_store  out  1  memory write enable.
mem_rdata  in  NUM_DOMAINS*8  memory read data; combinational from mem_rd_addr.
init_busy  out  1  high while CLEAR runs.

Behaviour:
- FSM states: CLEAR, RUN.
- Reset: state = CLEAR (or RUN if CLR_ON_RESET=0); clr_cnt = 0; starve_cnt = 0.
- Reset values of registered outputs: host_rvalid = 0, host_rdata = 0. All other outputs follow the state.
- Reset asserted mid-sweep or mid-access restarts the sweep at address 0 and drops any pending rvalid.
- CLEAR:
  - mem_store = 1, mem_wr_addr = clr_cnt, mem_wr_data = 0; clr_cnt increments every cycle.
  - cpu_stall = 1, host_gnt = 0, init_busy = 1.
  - Moves to RUN on the cycle after clr_cnt = DEPTH-1, so the sweep takes exactly DEPTH cycles with no wrap.
  - Host requests are held pending, not dropped.
- RUN, per-cycle owner selection:
  - The host owns the cycle if host_req and (no CPU request, or starve_cnt = STARVE_LIMIT).
  - Otherwise the CPU owns it. cpu_stall = (cpu_load | cpu_store) & host owns.
- CPU owner:
  - mem_rd_addr = cpu_rd_addr.
  - mem_wr_addr = cpu_wr_addr, mem_wr_data = cpu_wr_data, mem_store = cpu_store.
  - A combined load+store in one cycle is allowed; both ports are used.
- Host owner:
  - host_gnt = 1.
  - Write (host_we = 1): mem_store = 1 to host_addr with host_wdata.
  - Read (host_we = 0): mem_rd_addr = host_addr, mem_store = 0. Next cycle host_rvalid = 1 and host_rdata = the sampled mem_rdata. Latency is 1 cycle from grant.
- starve_cnt:
  - Increments when host_req is high and the host is denied, saturating at STARVE_LIMIT.
  - Clears on host grant or when host_req is low.
- With no requester, mem_store = 0 and mem_rd_addr = cpu_rd_addr.
- Same-address host write and CPU read cannot occur in one cycle, because a single owner holds both ports.
- Back-to-back host reads produce back-to-back rvalid pulses.

Decomposition:
- Shared package dmem_pkg holds:
  - ADDR_W = 8.
  - State encoding: CLEAR = 1'b0, RUN = 1'b1.
  - Function word_w(NUM_DOMAINS) = NUM_DOMAINS*8.
- There is no sub-module; the starvation counter and the clear counter stay inline.

Test Plan:
1. Reset for 1 cycle with CLR_ON_RESET=1:
   - init_busy is high for exactly 256 cycles.
   - mem_store writes 0 to addresses 0..255 in order.
   - cpu_stall = 1 throughout; RUN is entered on cycle 257.
2. Reset asserted at sweep address 100 -> the sweep restarts at 0 and a full 256 cycles follow.
3. In RUN, CPU store addr 0x10 data 0x3A with host_req idle -> mem_store = 1, mem_wr_addr = 0x10, cpu_stall = 0, host_gnt = 0.
4. Host read addr 0x10 with no CPU request -> host_gnt in the same cycle; next cycle host_rvalid = 1 and host_rdata = 0x3A.
5. cpu_load held high continuously with a host write to 0x20 pending:
   - The host is denied for 4 cycles.
   - On the 5th cycle host_gnt = 1, cpu_stall = 1, and 0x20 is written.
   - The cycle after, starve_cnt = 0 and the CPU resumes.
6. Host request arriving during CLEAR -> held; granted on the first RUN cycle with no CPU request.
